// File: rtl/fc_readout_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fc_readout_pkg
//  Purpose  : Shared constants, state encoding and the saturating-increment
//             helper for the FC-layer spike readout.
//  Contents : N_OUT, CLASS_W, SAT_W, ST_* state codes, state_t, sat_inc()
//  Revision : 1.0  initial release
// ============================================================================
package fc_readout_pkg;

  localparam int N_OUT   = 10;
  localparam int CLASS_W = 4;

  // Working width of sat_inc. Every spike counter is zero-extended to this
  // width and truncated back, so one helper serves any CNT_W up to SAT_W.
  localparam int SAT_W   = 8;

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  typedef enum logic [1:0] {
    S_ACCUM = ST_ACCUM,
    S_SCAN  = ST_SCAN,
    S_OUT   = ST_OUT
  } state_t;

  // Add one when inc is set, holding at max_val instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_inc(
    input logic [SAT_W-1:0] cnt,
    input logic             inc,
    input logic [SAT_W-1:0] max_val
  );
    if (inc && (cnt < max_val)) begin
      return cnt + SAT_W'(1);
    end
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/readout_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : readout_cmp
//  Purpose  : Combinational winner comparison for the rate-decoding scan.
//             A candidate beats the current best on a higher spike count,
//             then on a higher signed membrane, then on a lower index.
//  Ports    : first      in  force take (first candidate of a scan)
//             cand_cnt   in  candidate spike count
//             cand_v     in  candidate membrane (signed)
//             cand_idx   in  candidate neuron index
//             best_cnt   in  current best spike count
//             best_v     in  current best membrane (signed)
//             best_idx   in  current best neuron index
//             take_new   out candidate replaces best
//  Revision : 1.0  initial release
// ============================================================================
module readout_cmp #(
  parameter int CNT_W = 4,
  parameter int V_W   = 16,
  parameter int IDX_W = 4
) (
  input  logic             first,
  input  logic [CNT_W-1:0] cand_cnt,
  input  logic [V_W-1:0]   cand_v,
  input  logic [IDX_W-1:0] cand_idx,
  input  logic [CNT_W-1:0] best_cnt,
  input  logic [V_W-1:0]   best_v,
  input  logic [IDX_W-1:0] best_idx,
  output logic             take_new
);
  import fc_readout_pkg::*;

  logic w_cnt_gt;
  logic w_cnt_eq;
  logic w_v_gt;
  logic w_v_eq;
  logic w_idx_lt;

  assign w_cnt_gt = (cand_cnt > best_cnt);
  assign w_cnt_eq = (cand_cnt == best_cnt);
  // Membranes are Q5.11 two's complement; compare as signed.
  assign w_v_gt   = ($signed(cand_v) > $signed(best_v));
  assign w_v_eq   = (cand_v == best_v);
  // The scan runs in ascending index order, so a full tie never replaces the
  // best; the index term keeps the block correct for any visiting order.
  assign w_idx_lt = (cand_idx < best_idx);

  assign take_new = first
                  | w_cnt_gt
                  | (w_cnt_eq & w_v_gt)
                  | (w_cnt_eq & w_v_eq & w_idx_lt);

endmodule
`default_nettype wire

// File: rtl/fc_spike_readout.sv
`default_nettype none
// ============================================================================
//  Module   : fc_spike_readout
//  Purpose  : Counts FC-layer output spikes per class over T_STEPS timesteps,
//             then scans the counters one neuron per cycle and presents the
//             winning class on a valid/ready handshake (rate decoding, with
//             the final-step membrane as tie breaker).
//  Ports    : clk          in  clock, rising edge
//             rst          in  asynchronous active-high reset
//             flush        in  synchronous abort of the current inference
//             s_valid      in  spike/membrane beat valid (one timestep)
//             s_ready      out beat accepted when s_valid & s_ready
//             s_in         in  spike bit per neuron
//             v_in         in  membrane per neuron, neuron i at [V_W*i +: V_W]
//             class_valid  out result valid, held until taken
//             class_ready  in  result consumer ready
//             class_id     out winning neuron index
//             class_cnt    out spike count of the winner
//             busy         out high while scanning or presenting a result
//  Revision : 1.0  initial release
// ============================================================================
module fc_spike_readout #(
  parameter int N_OUT   = fc_readout_pkg::N_OUT,
  parameter int T_STEPS = 8,
  parameter int CNT_W   = 4,
  parameter int V_W     = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [N_OUT-1:0]                     s_in,
  input  logic [V_W*N_OUT-1:0]                 v_in,
  output logic                                 class_valid,
  input  logic                                 class_ready,
  output logic [fc_readout_pkg::CLASS_W-1:0]   class_id,
  output logic [CNT_W-1:0]                     class_cnt,
  output logic                                 busy
);
  import fc_readout_pkg::*;

  localparam int                  c_step_w    = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;
  localparam logic [c_step_w-1:0] c_last_step = c_step_w'(T_STEPS - 1);
  localparam int                  c_idx_w     = CLASS_W;
  localparam logic [c_idx_w-1:0]  c_last_idx  = c_idx_w'(N_OUT - 1);
  localparam logic [SAT_W-1:0]    c_cnt_max   = SAT_W'((2 ** CNT_W) - 1);

  state_t              r_state;
  state_t              w_state_next;

  logic [c_step_w-1:0] r_step;
  logic [c_idx_w-1:0]  r_idx;
  logic [CNT_W-1:0]    r_cnt [N_OUT];
  logic [V_W-1:0]      r_v   [N_OUT];

  logic [CNT_W-1:0]    r_best_cnt;
  logic [V_W-1:0]      r_best_v;
  logic [c_idx_w-1:0]  r_best_idx;
  logic                r_class_valid;

  logic [CNT_W-1:0]    w_cnt_inc [N_OUT];
  logic [V_W-1:0]      w_v_in    [N_OUT];
  logic [CNT_W-1:0]    w_cand_cnt;
  logic [V_W-1:0]      w_cand_v;
  logic                w_take;
  logic                w_accept;
  logic                w_last_beat;
  logic                w_handshake;

  // A beat presented together with flush is dropped.
  assign s_ready     = (r_state == S_ACCUM);
  assign w_accept    = s_valid & s_ready & ~flush;
  assign w_last_beat = w_accept & (r_step == c_last_step);
  assign w_handshake = r_class_valid & class_ready;

  // --------------------------------------------------------------------------
  // Per-neuron next count and membrane slice
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_neuron
    assign w_cnt_inc[gi] = CNT_W'(sat_inc(SAT_W'(r_cnt[gi]), s_in[gi], c_cnt_max));
    assign w_v_in[gi]    = v_in[V_W*gi +: V_W];
  end

  // --------------------------------------------------------------------------
  // Counter array and membrane latch. Membranes are captured only from the
  // final timestep; earlier beats contribute spikes alone.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_OUT; i++) begin
        r_cnt[i] <= '0;
        r_v[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (flush || w_handshake) begin
          r_cnt[i] <= '0;
        end else if (w_accept) begin
          r_cnt[i] <= w_cnt_inc[i];
        end
        if (w_last_beat) begin
          r_v[i] <= w_v_in[i];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scan comparator: candidate is the neuron addressed by r_idx
  // --------------------------------------------------------------------------
  assign w_cand_cnt = r_cnt[r_idx];
  assign w_cand_v   = r_v[r_idx];

  readout_cmp #(
    .CNT_W (CNT_W),
    .V_W   (V_W),
    .IDX_W (c_idx_w)
  ) u_cmp (
    .first    (r_idx == '0),
    .cand_cnt (w_cand_cnt),
    .cand_v   (w_cand_v),
    .cand_idx (r_idx),
    .best_cnt (r_best_cnt),
    .best_v   (r_best_v),
    .best_idx (r_best_idx),
    .take_new (w_take)
  );

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_ACCUM: if (w_last_beat)           w_state_next = S_SCAN;
      S_SCAN:  if (r_idx == c_last_idx)   w_state_next = S_OUT;
      S_OUT:   if (w_handshake)           w_state_next = S_ACCUM;
      default:                            w_state_next = S_ACCUM;
    endcase
    if (flush) begin
      w_state_next = S_ACCUM;
    end
  end

  // --------------------------------------------------------------------------
  // Step counter, scan index, best registers and result valid.
  // class_valid is raised on the first OUT cycle rather than on entry, so the
  // best registers have settled on the last candidate before it is shown.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step        <= '0;
      r_idx         <= '0;
      r_best_cnt    <= '0;
      r_best_v      <= '0;
      r_best_idx    <= '0;
      r_class_valid <= 1'b0;
    end else if (flush) begin
      r_step        <= '0;
      r_idx         <= '0;
      r_best_cnt    <= '0;
      r_best_v      <= '0;
      r_best_idx    <= '0;
      r_class_valid <= 1'b0;
    end else begin
      case (r_state)
        S_ACCUM: begin
          r_idx <= '0;
          if (w_accept) begin
            r_step <= (r_step == c_last_step) ? '0 : r_step + c_step_w'(1);
          end
        end
        S_SCAN: begin
          if (w_take) begin
            r_best_cnt <= w_cand_cnt;
            r_best_v   <= w_cand_v;
            r_best_idx <= r_idx;
          end
          r_idx <= (r_idx == c_last_idx) ? '0 : r_idx + c_idx_w'(1);
        end
        S_OUT: begin
          if (!r_class_valid) begin
            r_class_valid <= 1'b1;
          end else if (class_ready) begin
            r_class_valid <= 1'b0;
          end
        end
        default: begin
          r_idx <= '0;
        end
      endcase
    end
  end

  assign class_valid = r_class_valid;
  assign class_id    = r_best_idx;
  assign class_cnt   = r_best_cnt;
  assign busy        = (r_state != S_ACCUM);

endmodule
`default_nettype wire
